cursor_select_ctrl: RTL

CURSOR_SELECT_CTRL -- requirements
Module: cursor_select_ctrl

---
 rtl/cursor_select_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/cursor_select_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cursor_select_ctrl
// Description : Board cursor with wrap-around movement and a two-cell
//               selection handshake (IDLE -> ONE -> PAIR -> IDLE).
//               Optional held-direction auto-repeat, enabled by defining
//               the macro CURSOR_AUTO_REPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module cursor_select_ctrl #(
    parameter int          COLS          = 10,
    parameter int          ROWS          = 8,
    parameter logic [23:0] REPEAT_DELAY  = 24'd5000000,
    parameter logic [23:0] REPEAT_PERIOD = 24'd1500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] operation,
    input  logic       pair_ready,
    output logic [3:0] cursor_x,
    output logic [3:0] cursor_y,
    output logic       sel_valid,
    output logic [3:0] sel_x,
    output logic [3:0] sel_y,
    output logic       pair_valid,
    output logic [3:0] pair_x0,
    output logic [3:0] pair_y0,
    output logic [3:0] pair_x1,
    output logic [3:0] pair_y1
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ONE  = 2'd1,
        ST_PAIR = 2'd2
    } state_t;

    localparam logic [3:0] c_x_max = 4'(COLS - 1);
    localparam logic [3:0] c_y_max = 4'(ROWS - 1);

    state_t     r_state;
    state_t     w_state_next;
    logic [5:0] r_op_q;
    logic       r_armed;
    logic [5:0] w_evt;
    logic [3:0] w_mv;          // [0] left, [1] right, [2] up, [3] down
    logic       w_cap_sel;
    logic       w_cap_pair;
    logic [3:0] r_cursor_x;
    logic [3:0] r_cursor_y;
    logic [3:0] r_sel_x;
    logic [3:0] r_sel_y;
    logic [3:0] r_pair_x0;
    logic [3:0] r_pair_y0;
    logic [3:0] r_pair_x1;
    logic [3:0] r_pair_y1;

    // Edge detect; events are suppressed on the first clock after reset so
    // keys held through reset release do not fire.
    assign w_evt = r_armed ? (operation & ~r_op_q) : 6'd0;

    // Key history register and post-reset arm flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_q  <= 6'd0;
            r_armed <= 1'b0;
        end else begin
            r_op_q  <= operation;
            r_armed <= 1'b1;
        end
    end

`ifdef CURSOR_AUTO_REPEAT_EN
    logic [23:0] r_rep_cnt;
    logic        r_rep_period;
    logic        w_dir_chg;
    logic        w_dir_any;
    logic        w_rep_fire;

    // Repeat fires when the held pattern has aged past the current threshold
    always_comb begin
        w_dir_chg  = (operation[5:2] != r_op_q[5:2]);
        w_dir_any  = |operation[5:2];
        w_rep_fire = r_armed && !w_dir_chg && w_dir_any &&
                     (r_rep_period ? (r_rep_cnt == REPEAT_PERIOD)
                                   : (r_rep_cnt == REPEAT_DELAY));
        w_mv       = w_evt[5:2] | (w_rep_fire ? operation[5:2] : 4'd0);
    end

    // Repeat counter: restart on any direction change, clear when released
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rep_cnt    <= 24'd0;
            r_rep_period <= 1'b0;
        end else if (!w_dir_any) begin
            r_rep_cnt    <= 24'd0;
            r_rep_period <= 1'b0;
        end else if (w_dir_chg || !r_armed) begin
            r_rep_cnt    <= 24'd1;
            r_rep_period <= 1'b0;
        end else if (w_rep_fire) begin
            r_rep_cnt    <= 24'd1;
            r_rep_period <= 1'b1;
        end else begin
            r_rep_cnt    <= r_rep_cnt + 24'd1;
        end
    end
`else
    logic w_unused_rep;
    assign w_unused_rep = ^{REPEAT_DELAY, REPEAT_PERIOD};
    assign w_mv         = w_evt[5:2];
`endif

    // Cursor movement with wrap; left beats right, up beats down
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cursor_x <= 4'd0;
            r_cursor_y <= 4'd0;
        end else begin
            if (w_mv[0])
                r_cursor_x <= (r_cursor_x == 4'd0) ? c_x_max : r_cursor_x - 4'd1;
            else if (w_mv[1])
                r_cursor_x <= (r_cursor_x == c_x_max) ? 4'd0 : r_cursor_x + 4'd1;
            if (w_mv[2])
                r_cursor_y <= (r_cursor_y == 4'd0) ? c_y_max : r_cursor_y - 4'd1;
            else if (w_mv[3])
                r_cursor_y <= (r_cursor_y == c_y_max) ? 4'd0 : r_cursor_y + 4'd1;
        end
    end

    // Selection FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    // Selection FSM next state; cancel outranks select while holding one cell
    always_comb begin
        w_state_next = r_state;
        w_cap_sel    = 1'b0;
        w_cap_pair   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_evt[0]) begin
                    w_cap_sel    = 1'b1;
                    w_state_next = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_evt[1]) begin
                    w_state_next = ST_IDLE;
                end else if (w_evt[0]) begin
                    if (r_cursor_x == r_sel_x && r_cursor_y == r_sel_y) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_cap_pair   = 1'b1;
                        w_state_next = ST_PAIR;
                    end
                end
            end
            ST_PAIR: begin
                if (pair_ready) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Selection and pair coordinate capture (pre-move cursor value)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel_x   <= 4'd0;
            r_sel_y   <= 4'd0;
            r_pair_x0 <= 4'd0;
            r_pair_y0 <= 4'd0;
            r_pair_x1 <= 4'd0;
            r_pair_y1 <= 4'd0;
        end else begin
            if (w_cap_sel) begin
                r_sel_x <= r_cursor_x;
                r_sel_y <= r_cursor_y;
            end
            if (w_cap_pair) begin
                r_pair_x0 <= r_sel_x;
                r_pair_y0 <= r_sel_y;
                r_pair_x1 <= r_cursor_x;
                r_pair_y1 <= r_cursor_y;
            end
        end
    end

    assign cursor_x   = r_cursor_x;
    assign cursor_y   = r_cursor_y;
    assign sel_x      = r_sel_x;
    assign sel_y      = r_sel_y;
    assign pair_x0    = r_pair_x0;
    assign pair_y0    = r_pair_y0;
    assign pair_x1    = r_pair_x1;
    assign pair_y1    = r_pair_y1;
    assign sel_valid  = (r_state != ST_IDLE);
    assign pair_valid = (r_state == ST_PAIR);

endmodule
`default_nettype wire
